// File: rtl/csa_stream_accumulator_if.sv
// Operand/result handshake bundle for csa_stream_accumulator.
// master = producer/consumer side, slave = accumulator side.
interface csa_stream_accumulator_if #(
  parameter int IN_W  = 21,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Carry-save stream accumulator: one 3:2 compression per beat, final CPA
// on the last beat. Ports: clk, rst_n (async low), bus (slave modport).
module csa_stream_accumulator #(
  parameter int IN_W   = 21,
  parameter int ACC_W  = 24,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst_n,
  csa_stream_accumulator_if.slave bus
);

  localparam int GAP = ACC_W - IN_W;
  localparam logic [CNT_W-1:0] BOUND = CNT_W'(1) << GAP;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [ACC_W-1:0] s;
  logic [ACC_W-1:0] c;
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] s_nx;
  logic [ACC_W-1:0] c_nx;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             ext;
  logic             beat;

  assign ext  = SIGNED ? bus.in_data[IN_W-1] : 1'b0;
  assign x    = {{GAP{ext}}, bus.in_data};
  assign s_nx = s ^ c ^ x;
  // Majority carries move up one weight; the top carry falls off (wrap).
  assign c_nx = ((s & c) | (s & x) | (c & x)) << 1;

  assign bus.in_ready = (state == ACCUM);
  assign beat = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM:   if (beat && bus.in_last) state_nx = RESOLVE;
      RESOLVE: state_nx = OUTPUT;
      OUTPUT:  if (bus.out_ready) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s             <= '0;
      c             <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (beat) begin
            s <= s_nx;
            c <= c_nx;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
            // Past 2^GAP beats the sum may exceed ACC_W bits.
            if (cnt == BOUND) ovf <= 1'b1;
          end
        end
        RESOLVE: begin
          bus.out_sum   <= s + c;
          bus.out_count <= cnt;
          bus.out_ovf   <= ovf;
          bus.out_valid <= 1'b1;
          s             <= '0;
          c             <= '0;
          cnt           <= '0;
          ovf           <= 1'b0;
        end
        OUTPUT: begin
          if (bus.out_ready) bus.out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench: unsigned and signed instances share one stimulus
// stream; results are compared against a plain-arithmetic model.
module tb_csa_stream_accumulator;
  localparam int IN_W  = 21;
  localparam int ACC_W = 24;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) ifu ();
  csa_stream_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) ifs ();

  assign ifs.in_valid  = ifu.in_valid;
  assign ifs.in_data   = ifu.in_data;
  assign ifs.in_last   = ifu.in_last;
  assign ifs.out_ready = ifu.out_ready;

  csa_stream_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .SIGNED(1'b0), .CNT_W(CNT_W)
  ) dut_u (.clk(clk), .rst_n(rst_n), .bus(ifu.slave));

  csa_stream_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .SIGNED(1'b1), .CNT_W(CNT_W)
  ) dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic [IN_W-1:0] q[$];

  function automatic logic [ACC_W-1:0] ref_sum(input bit sgn);
    longint acc = 0;
    foreach (q[i]) begin
      longint v = longint'(q[i]);
      if (sgn && q[i][IN_W-1]) v = v - (longint'(1) << IN_W);
      acc = acc + v;
    end
    return ACC_W'(acc);
  endfunction

  function automatic logic [CNT_W-1:0] ref_cnt();
    return (q.size() > 255) ? CNT_W'(255) : CNT_W'(q.size());
  endfunction

  function automatic logic ref_ovf();
    return q.size() > (1 << (ACC_W - IN_W));
  endfunction

  task automatic drive_beat(input logic [IN_W-1:0] d, input bit last);
    int k = 0;
    ifu.in_valid = 1'b1;
    ifu.in_data  = d;
    ifu.in_last  = last;
    while (!ifu.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_accept: in_ready got 0 want 1 (timeout)");
    end
    @(negedge clk);
    ifu.in_valid = 1'b0;
    ifu.in_last  = 1'b0;
  endtask

  task automatic send_q();
    foreach (q[i]) drive_beat(q[i], i == q.size() - 1);
  endtask

  task automatic collect(input int delay, output bit ok,
                         output logic [ACC_W-1:0] su,
                         output logic [ACC_W-1:0] ss,
                         output logic [CNT_W-1:0] cu,
                         output logic ou);
    int k = 0;
    while (!ifu.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = ifu.out_valid && ifs.out_valid;
    repeat (delay) @(negedge clk);
    su = ifu.out_sum;
    ss = ifs.out_sum;
    cu = ifu.out_count;
    ou = ifu.out_ovf;
    ifu.out_ready = 1'b1;
    @(negedge clk);
    ifu.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifu.in_valid = 1'b0;
    ifu.in_data = '0;
    ifu.in_last = 1'b0;
    ifu.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ifu.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", ifu.out_valid);
    end
    n_tests++;
    if (ifu.out_sum !== '0) begin
      n_fail++;
      $display("FAIL reset_out_sum: got %h want 0", ifu.out_sum);
    end
    n_tests++;
    if (ifu.out_count !== '0 || ifu.out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_count_ovf: got %h/%b want 0/0",
               ifu.out_count, ifu.out_ovf);
    end
    n_tests++;
    if (ifu.in_ready !== 1'b1 || ifs.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b%b want 11",
               ifu.in_ready, ifs.in_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [ACC_W-1:0] su, ss;
    logic [CNT_W-1:0] cu;
    logic ou;
    drive_beat(21'h1FFFFF, 1'b1);
    n_tests++;
    if (ifu.out_valid !== 1'b0 || ifu.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resolve: valid/ready got %b/%b want 0/0",
               ifu.out_valid, ifu.in_ready);
    end
    collect(0, ok, su, ss, cu, ou);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_valid: got 0 want 1 (timeout)");
    end
    n_tests++;
    if (su !== 24'h1FFFFF || cu !== 8'd1 || ou !== 1'b0) begin
      n_fail++;
      $display("FAIL single_unsigned: got %h/%0d/%b want 1fffff/1/0",
               su, cu, ou);
    end
    n_tests++;
    if (ss !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL single_signed: got %h want ffffff", ss);
    end
    n_tests++;
    if (ifu.out_valid !== 1'b0 || ifu.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release: valid/ready got %b/%b want 0/1",
               ifu.out_valid, ifu.in_ready);
    end
  endtask

  task automatic test_ovf_bound();
    bit ok;
    logic [ACC_W-1:0] su, ss;
    logic [CNT_W-1:0] cu;
    logic ou;
    q = {};
    repeat (8) q.push_back(21'h1FFFFF);
    send_q();
    collect(0, ok, su, ss, cu, ou);
    n_tests++;
    if (!ok || su !== 24'hFFFFF8 || cu !== 8'd8 || ou !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_8beats: got %b/%h/%0d/%b want 1/fffff8/8/0",
               ok, su, cu, ou);
    end
    q.push_back(21'h1FFFFF);
    send_q();
    collect(1, ok, su, ss, cu, ou);
    n_tests++;
    if (!ok || su !== 24'h1FFFF7 || cu !== 8'd9 || ou !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_9beats: got %b/%h/%0d/%b want 1/1ffff7/9/1",
               ok, su, cu, ou);
    end
    n_tests++;
    if (ss !== 24'hFFFFF7 || ifs.out_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_9beats_signed: got %h/%b want fffff7/1",
               ss, ifs.out_ovf);
    end
  endtask

  task automatic test_signed();
    bit ok;
    logic [ACC_W-1:0] su, ss;
    logic [CNT_W-1:0] cu;
    logic ou;
    q = {21'h1FFFFF, 21'h000003};
    send_q();
    collect(2, ok, su, ss, cu, ou);
    n_tests++;
    if (!ok || ss !== 24'h000002) begin
      n_fail++;
      $display("FAIL signed_sum: got %b/%h want 1/000002", ok, ss);
    end
    n_tests++;
    if (su !== 24'h200002 || cu !== 8'd2) begin
      n_fail++;
      $display("FAIL signed_pair_unsigned: got %h/%0d want 200002/2",
               su, cu);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [ACC_W-1:0] su, ss;
    logic [CNT_W-1:0] cu;
    logic ou;
    int k = 0;
    drive_beat(21'h00ABCD, 1'b1);
    while (!ifu.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      ifu.in_valid = ~ifu.in_valid;
      ifu.in_data  = IN_W'($urandom);
      ifu.in_last  = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ifu.out_valid !== 1'b1 || ifu.in_ready !== 1'b0 ||
          ifu.out_sum !== 24'h00ABCD || ifu.out_count !== 8'd1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v/r/sum/cnt got %b/%b/%h/%0d want 1/0/00abcd/1",
                 i, ifu.out_valid, ifu.in_ready, ifu.out_sum,
                 ifu.out_count);
      end
    end
    ifu.in_valid = 1'b0;
    ifu.in_last  = 1'b0;
    collect(0, ok, su, ss, cu, ou);
    drive_beat(21'h000007, 1'b1);
    collect(0, ok, su, ss, cu, ou);
    n_tests++;
    if (!ok || su !== 24'h000007 || cu !== 8'd1 || ou !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after: got %b/%h/%0d/%b want 1/000007/1/0",
               ok, su, cu, ou);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [ACC_W-1:0] su, ss;
    logic [CNT_W-1:0] cu;
    logic ou;
    int seen = 0;
    repeat (3) drive_beat(21'h000100, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ifu.out_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_output: got %0d valid cycles want 0", seen);
    end
    drive_beat(21'h000005, 1'b1);
    collect(0, ok, su, ss, cu, ou);
    n_tests++;
    if (!ok || su !== 24'h000005 || cu !== 8'd1 || ou !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got %b/%h/%0d/%b want 1/000005/1/0",
               ok, su, cu, ou);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    logic [ACC_W-1:0] su, ss;
    logic [CNT_W-1:0] cu;
    logic ou;
    q = {};
    repeat (260) q.push_back(IN_W'($urandom));
    send_q();
    collect(0, ok, su, ss, cu, ou);
    n_tests++;
    if (!ok || cu !== 8'd255 || ou !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_count: got %b/%0d/%b want 1/255/1", ok, cu, ou);
    end
    n_tests++;
    if (su !== ref_sum(1'b0) || ss !== ref_sum(1'b1)) begin
      n_fail++;
      $display("FAIL sat_sum: got %h/%h want %h/%h",
               su, ss, ref_sum(1'b0), ref_sum(1'b1));
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [ACC_W-1:0] su, ss;
    logic [CNT_W-1:0] cu;
    logic ou;
    for (int t = 0; t < 24; t++) begin
      int n = $urandom_range(1, 12);
      q = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0)
          q.push_back(($urandom_range(0, 1) == 1) ? 21'h1FFFFF : 21'h100000);
        else
          q.push_back(IN_W'($urandom));
      end
      send_q();
      collect($urandom_range(0, 3), ok, su, ss, cu, ou);
      n_tests++;
      if (!ok || su !== ref_sum(1'b0) || ss !== ref_sum(1'b1) ||
          cu !== ref_cnt() || ou !== ref_ovf()) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %b/%h/%h/%0d/%b want 1/%h/%h/%0d/%b",
                 t, ok, su, ss, cu, ou, ref_sum(1'b0), ref_sum(1'b1),
                 ref_cnt(), ref_ovf());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ovf_bound();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
